// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch queue.
// Holds the fetch FSM states, default widths and the fetch entry layout.
package ifetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory-side and decode-side handshakes of the fetch queue.
// master = fetch unit, slave = memory/decode environment.
interface ifetch_queue_if #(
  parameter int ADDR_W  = ifetch_pkg::ADDR_W_DEF,
  parameter int INSTR_W = ifetch_pkg::INSTR_W_DEF
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Small register FIFO holding {pc, instr} fetch entries.
// Head entry is read straight from storage flops; clear wins over push/pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // Next pointers, count and storage; pointers wrap by width.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: one outstanding imem read, results buffered for decode.
// Optional IFETCH_STALL_CNT_EN adds a saturating decode-starve counter.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  input  logic              flush,
  ifetch_queue_if.master    bus
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = ADDR_W + INSTR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              req_valid_q, req_valid_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic [CW1-1:0]    cnt_after;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [EW-1:0]     head;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   ({req_pc_q, bus.imem_rsp_data}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.imem_req_valid = req_valid_q & ~flush;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.id_valid       = ~empty;
  assign bus.id_pc          = head[EW-1:INSTR_W];
  assign bus.id_instr       = head[INSTR_W-1:0];
  assign pc_inc             = accept;

  // Handshake qualifiers; flush masks every transfer in its cycle.
  always_comb begin
    accept    = req_valid_q & ~flush & bus.imem_req_ready;
    pop       = ~empty & bus.id_ready & ~flush;
    push      = (state_q == WAIT) & bus.imem_rsp_valid
              & ~drop_q & ~flush;
    cnt_after = {1'b0, count}
              + CW1'(push)
              - CW1'(pop);
    slot_free = (cnt_after < CW1'(DEPTH));
  end

  // Fetch FSM next state; each entry to REQ samples a fresh PC.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    unique case (state_q)
      IDLE: begin
        if (flush || !full) begin
          state_d    = REQ;
          req_addr_d = pc_addr;
        end
      end
      REQ: begin
        if (flush) begin
          req_addr_d = pc_addr;
        end else if (accept) begin
          state_d  = WAIT;
          req_pc_d = req_addr_q;
        end
      end
      WAIT: begin
        if (flush) begin
          // A response landing with the flush is the one to drop.
          if (bus.imem_rsp_valid) begin
            drop_d     = 1'b0;
            state_d    = REQ;
            req_addr_d = pc_addr;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || slot_free) begin
            state_d    = REQ;
            req_addr_d = pc_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_valid_d = (state_d == REQ);
  end

  // FSM and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  // Count cycles decode waits on an empty queue; saturates.
  always_comb begin
    stall_d = stall_q;
    if (bus.id_ready && empty && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a latency-programmable imem model.
// Build with IFETCH_STALL_CNT_EN to also exercise the stall counter.
module tb_ifetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] pc_addr;
  logic       pc_inc;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] s_stall;
  logic [15:0] stq[$];
`endif

  ifetch_queue_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  ifetch_queue #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .DEPTH   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_addr (pc_addr),
    .pc_inc  (pc_inc),
    .flush   (flush),
    .bus     (bus)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int inc_cnt;
  int vdrop;
  int lat;
  int left;
  bit pend, acc, inc_seen, ovr_en, dead_seen, seen_v;
  logic [7:0]  paddr;
  logic [15:0] ovr_data;
  logic [23:0] popq[$];

  logic        s_req_valid, s_pc_inc, s_id_valid;
  logic [7:0]  s_req_addr, s_id_pc;
  logic [15:0] s_id_instr;

  function automatic logic [15:0] fdat(input logic [7:0] a);
    return {a ^ 8'hB5, a ^ 8'hB5};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Sample before the edge, then advance PC and the memory model.
  task automatic tick;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_pc_inc    = pc_inc;
    s_id_valid  = bus.id_valid;
    s_id_instr  = bus.id_instr;
    s_id_pc     = bus.id_pc;
`ifdef IFETCH_STALL_CNT_EN
    s_stall     = stall_cnt;
`endif
    acc      = s_req_valid & bus.imem_req_ready;
    inc_seen = s_pc_inc;
    if (s_pc_inc) inc_cnt++;
    if (s_id_valid && s_id_instr == 16'hDEAD) dead_seen = 1'b1;
    if (s_id_valid && bus.id_ready && !flush && !rst) begin
      popq.push_back({s_id_pc, s_id_instr});
`ifdef IFETCH_STALL_CNT_EN
      stq.push_back(s_stall);
`endif
    end
    @(posedge clk);
    #1;
    if (inc_seen) pc_addr = pc_addr + 8'd1;
    bus.imem_rsp_valid = 1'b0;
    if (acc && !rst) begin
      pend  = 1'b1;
      left  = lat;
      paddr = s_req_addr;
    end
    if (pend) begin
      left--;
      if (left == 0) begin
        pend = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ovr_en ? ovr_data : fdat(paddr);
        ovr_en = 1'b0;
      end
    end
  endtask

  task automatic rst_on;
    rst = 1'b1;
    flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    pend = 1'b0;
    ovr_en = 1'b0;
    tick();
    tick();
    popq.delete();
    inc_cnt = 0;
    dead_seen = 1'b0;
    vdrop = 0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pc_addr = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.id_ready = 1'b0;
    lat = 1;
    left = 0;
    paddr = '0;
    ovr_data = 16'hDEAD;
    inc_cnt = 0;

    // reset values
    rst_on();
    check("rst_req_valid", 32'(s_req_valid), 0);
    check("rst_req_addr", 32'(s_req_addr), 0);
    check("rst_pc_inc", 32'(s_pc_inc), 0);
    check("rst_id_valid", 32'(s_id_valid), 0);
    check("rst_id_instr", 32'(s_id_instr), 0);
    check("rst_id_pc", 32'(s_id_pc), 0);

    // single fetch, 1-cycle memory
    pc_addr = 8'h10;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    tick();
    check("t1_c0_req_valid", 32'(s_req_valid), 0);
    tick();
    check("t1_c1_req_valid", 32'(s_req_valid), 1);
    check("t1_c1_req_addr", 32'(s_req_addr), 32'h10);
    check("t1_c1_pc_inc", 32'(s_pc_inc), 1);
    tick();
    check("t1_c2_pc_inc", 32'(s_pc_inc), 0);
    check("t1_c2_id_valid", 32'(s_id_valid), 0);
    check("t1_inc_cnt", 32'(inc_cnt), 1);
    tick();
    check("t1_c3_id_valid", 32'(s_id_valid), 1);
    check("t1_c3_id_instr", 32'(s_id_instr), 32'hA5A5);
    check("t1_c3_id_pc", 32'(s_id_pc), 32'h10);

    // fill to full with decode stalled, then drain
    rst_on();
    pc_addr = 8'h00;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    repeat (10) tick();
    check("t2_inc_cnt", 32'(inc_cnt), 2);
    check("t2_pc_addr", 32'(pc_addr), 2);
    check("t2_req_valid", 32'(s_req_valid), 0);
    check("t2_id_valid", 32'(s_id_valid), 1);
    check("t2_head_pc", 32'(s_id_pc), 0);
    bus.id_ready = 1'b1;
    repeat (8) tick();
    check("t2_npop", 32'(popq.size() >= 3), 1);
    check("t2_pop0", 32'(popq[0]), {8'h00, fdat(8'h00)});
    check("t2_pop1", 32'(popq[1]), {8'h01, fdat(8'h01)});
    check("t2_pop2", 32'(popq[2]), {8'h02, fdat(8'h02)});

    // memory not ready for 5 cycles
    rst_on();
    pc_addr = 8'h20;
    bus.id_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    tick();
    pc_addr = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 32'(s_req_valid), 1);
      check("t3_hold_addr", 32'(s_req_addr), 32'h20);
      check("t3_hold_inc", 32'(s_pc_inc), 0);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    check("t3_acc_inc", 32'(s_pc_inc), 1);
    check("t3_acc_addr", 32'(s_req_addr), 32'h20);
    repeat (4) tick();
    check("t3_pop0", 32'(popq[0]), {8'h20, fdat(8'h20)});

    // flush while a request is offered and ready is high
    rst_on();
    pc_addr = 8'h60;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    tick();
    flush = 1'b1;
    pc_addr = 8'h61;
    tick();
    check("t3b_flush_valid", 32'(s_req_valid), 0);
    check("t3b_flush_inc", 32'(s_pc_inc), 0);
    flush = 1'b0;
    tick();
    check("t3b_new_addr", 32'(s_req_addr), 32'h61);
    check("t3b_new_inc", 32'(s_pc_inc), 1);

    // flush in WAIT; stale response must vanish
    rst_on();
    pc_addr = 8'h30;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    lat = 4;
    ovr_en = 1'b1;
    ovr_data = 16'hDEAD;
    rst = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    pc_addr = 8'h40;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    tick();
    check("t4_req_valid", 32'(s_req_valid), 1);
    check("t4_req_addr", 32'(s_req_addr), 32'h40);
    repeat (6) tick();
    check("t4_dead", 32'(dead_seen), 0);
    check("t4_npop", 32'(popq.size()), 1);
    check("t4_pop0", 32'(popq[0]), {8'h40, fdat(8'h40)});

    // push and pop together at count 1, across pointer wrap
    rst_on();
    pc_addr = 8'h50;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      bus.id_ready = bus.imem_rsp_valid;
      if (seen_v && !s_id_valid) vdrop++;
      if (s_id_valid) seen_v = 1'b1;
      if (popq.size() >= 10) break;
    end
    check("t5_npop", 32'(popq.size()), 10);
    check("t5_vdrop", 32'(vdrop), 0);
    for (int i = 0; i < 10; i++) begin
      check("t5_seq", 32'(popq[i]),
            {8'h50 + 8'(i), fdat(8'h50 + 8'(i))});
    end

`ifdef IFETCH_STALL_CNT_EN
    // stall counter: 4 per instruction at latency 4
    rst_on();
    stq.delete();
    check("t6_rst_zero", 32'(s_stall), 0);
    pc_addr = 8'h70;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    lat = 4;
    rst = 1'b0;
    repeat (20) tick();
    check("t6_npop", 32'(stq.size()), 3);
    check("t6_first", 32'(stq[0]), 6);
    check("t6_d1", 32'(stq[1] - stq[0]), 4);
    check("t6_d2", 32'(stq[2] - stq[1]), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t6_no_clr", 32'(s_stall >= 16'd14), 1);
    rst = 1'b1;
    tick();
    tick();
    check("t6_rst_clr", 32'(s_stall), 0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
